// File: rtl/bcd_time_counter.sv
// Multi-digit BCD up/down time counter with load validation,
// wrap/saturate limits and a registered carry for cascading.
module bcd_time_counter #(
  parameter int DIGITS      = 2,
  parameter int TOP_MOD     = 6,
  parameter int SAT_DEFAULT = 0
) (
  input  logic                Clk,
  input  logic                nReset,
  input  logic                Enable,
  input  logic                Up,
  input  logic                Load,
  input  logic [4*DIGITS-1:0] LoadValue,
  input  logic                SatMode,
  output logic [4*DIGITS-1:0] PresentTime,
  output logic                Carry,
  output logic                AtLimit,
  output logic                LoadErr
);

  localparam int W = 4 * DIGITS;
  localparam logic [3:0] TOPM = 4'(TOP_MOD - 1);

  function automatic logic [3:0] dmax(input int i);
    return (i == DIGITS - 1) ? TOPM : 4'd9;
  endfunction

  logic [W-1:0] max_v;
  logic [W-1:0] inc_v;
  logic [W-1:0] dec_v;
  logic [W-1:0] nxt;
  logic         inc_wrap;
  logic         dec_wrap;
  logic         ld_ok;
  logic         wrap;
  logic         sat;
  logic         carry_d;
  logic         lerr_d;
  logic         lim_d;
  logic         armed_q;

  // Ripple both directions; a wrap flag left set means every digit rolled.
  always_comb begin
    max_v    = '0;
    inc_v    = '0;
    dec_v    = '0;
    ld_ok    = 1'b1;
    inc_wrap = 1'b1;
    dec_wrap = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      max_v[i*4 +: 4] = dmax(i);
      if (LoadValue[i*4 +: 4] > dmax(i))
        ld_ok = 1'b0;
      if (!inc_wrap) begin
        inc_v[i*4 +: 4] = PresentTime[i*4 +: 4];
      end else if (PresentTime[i*4 +: 4] == dmax(i)) begin
        inc_v[i*4 +: 4] = 4'd0;
      end else begin
        inc_v[i*4 +: 4] = PresentTime[i*4 +: 4] + 4'd1;
        inc_wrap = 1'b0;
      end
      if (!dec_wrap) begin
        dec_v[i*4 +: 4] = PresentTime[i*4 +: 4];
      end else if (PresentTime[i*4 +: 4] == 4'd0) begin
        dec_v[i*4 +: 4] = dmax(i);
      end else begin
        dec_v[i*4 +: 4] = PresentTime[i*4 +: 4] - 4'd1;
        dec_wrap = 1'b0;
      end
    end
  end

  // Until the first edge after reset the mode comes from SAT_DEFAULT.
  always_comb begin
    sat     = armed_q ? SatMode : (SAT_DEFAULT != 0);
    wrap    = Up ? inc_wrap : dec_wrap;
    nxt     = PresentTime;
    carry_d = 1'b0;
    lerr_d  = 1'b0;
    if (Load) begin
      if (ld_ok)
        nxt = LoadValue;
      else
        lerr_d = 1'b1;
    end else if (Enable && !(wrap && sat)) begin
      nxt     = Up ? inc_v : dec_v;
      carry_d = wrap;
    end
    lim_d = Up ? (nxt == max_v) : (nxt == '0);
  end

  always_ff @(posedge Clk or posedge nReset) begin
    if (nReset) begin
      PresentTime <= '0;
      Carry       <= 1'b0;
      AtLimit     <= 1'b0;
      LoadErr     <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      PresentTime <= nxt;
      Carry       <= carry_d;
      AtLimit     <= lim_d;
      LoadErr     <= lerr_d;
      armed_q     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_time_counter.sv
// Scoreboard bench for bcd_time_counter: 2-digit mod-60,
// 3-digit mod-1000 and 1-digit mod-2 instances.
module tb_bcd_time_counter;

  typedef struct packed {
    logic [11:0] pt;
    logic        c;
    logic        al;
    logic        le;
  } exp_t;

  logic        Clk;
  logic        nReset;
  logic        Enable;
  logic        Up;
  logic        Load;
  logic        SatMode;
  logic [11:0] lv;

  logic [7:0]  pt1;
  logic [11:0] pt2;
  logic [3:0]  pt3;
  logic        c1, al1, le1;
  logic        c2, al2, le2;
  logic        c3, al3, le3;

  bcd_time_counter #(.DIGITS(2), .TOP_MOD(6), .SAT_DEFAULT(0)) dut1 (
    .Clk(Clk), .nReset(nReset), .Enable(Enable), .Up(Up), .Load(Load),
    .LoadValue(lv[7:0]), .SatMode(SatMode), .PresentTime(pt1),
    .Carry(c1), .AtLimit(al1), .LoadErr(le1)
  );

  bcd_time_counter #(.DIGITS(3), .TOP_MOD(10), .SAT_DEFAULT(0)) dut2 (
    .Clk(Clk), .nReset(nReset), .Enable(Enable), .Up(Up), .Load(Load),
    .LoadValue(lv), .SatMode(SatMode), .PresentTime(pt2),
    .Carry(c2), .AtLimit(al2), .LoadErr(le2)
  );

  bcd_time_counter #(.DIGITS(1), .TOP_MOD(2), .SAT_DEFAULT(0)) dut3 (
    .Clk(Clk), .nReset(nReset), .Enable(Enable), .Up(Up), .Load(Load),
    .LoadValue(lv[3:0]), .SatMode(SatMode), .PresentTime(pt3),
    .Carry(c3), .AtLimit(al3), .LoadErr(le3)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m1 = 0;
  int   m2 = 0;
  int   m3 = 0;

  // Integer model: the count is a plain number in [0, span).
  function automatic exp_t model(input int nd, input int top, inout int m,
                                 input logic ld, input logic [11:0] v,
                                 input logic en, input logic up,
                                 input logic sat);
    exp_t e;
    int   span;
    int   val;
    int   p;
    int   d;
    bit   ok;
    span = top;
    for (int i = 0; i < nd - 1; i++) span = span * 10;
    val = 0;
    p = 1;
    ok = 1'b1;
    for (int i = 0; i < nd; i++) begin
      d = int'(v[i*4 +: 4]);
      if (d > ((i == nd - 1) ? top - 1 : 9)) ok = 1'b0;
      val = val + d * p;
      p = p * 10;
    end
    e = '0;
    if (ld) begin
      if (ok) m = val;
      else e.le = 1'b1;
    end else if (en) begin
      if (up) begin
        if (m == span - 1) begin
          if (!sat) begin m = 0; e.c = 1'b1; end
        end else m = m + 1;
      end else begin
        if (m == 0) begin
          if (!sat) begin m = span - 1; e.c = 1'b1; end
        end else m = m - 1;
      end
    end
    e.al = up ? (m == span - 1) : (m == 0);
    p = 1;
    for (int i = 0; i < 3; i++) begin
      e.pt[i*4 +: 4] = 4'((m / p) % 10);
      p = p * 10;
    end
    return e;
  endfunction

  function automatic exp_t obs(input int which);
    exp_t g;
    case (which)
      1:       g = '{pt: {4'h0, pt1}, c: c1, al: al1, le: le1};
      2:       g = '{pt: pt2, c: c2, al: al2, le: le2};
      default: g = '{pt: {8'h0, pt3}, c: c3, al: al3, le: le3};
    endcase
    return g;
  endfunction

  task automatic drive(input int which, input logic ld, input logic [11:0] v,
                       input logic en, input logic up, input logic sat);
    Load = ld;
    LoadValue_set(v);
    Enable = en;
    Up = up;
    SatMode = sat;
    case (which)
      1:       sb.push_back(model(2, 6, m1, ld, v, en, up, sat));
      2:       sb.push_back(model(3, 10, m2, ld, v, en, up, sat));
      default: sb.push_back(model(1, 2, m3, ld, v, en, up, sat));
    endcase
  endtask

  task automatic LoadValue_set(input logic [11:0] v);
    lv = v;
  endtask

  task automatic test_reset;
    exp_t e;
    exp_t g;
    nReset = 1'b1;
    #1;
    m1 = 0; m2 = 0; m3 = 0;
    g = obs(1);
    n_cmp++;
    if (g !== exp_t'(0)) begin
      n_bad++;
      $display("FAIL reset_state: got %h want %h", g, exp_t'(0));
    end
    @(posedge Clk); #1;
    nReset = 1'b0;
    drive(1, 1'b0, 12'h0, 1'b0, 1'b0, 1'b0);
    @(posedge Clk); #1;
    e = sb.pop_front(); g = obs(1); n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL reset_idle_atlimit: got %h want %h", g, e);
    end
  endtask

  task automatic test_count_up;
    exp_t e;
    exp_t g;
    for (int i = 0; i < 60; i++) begin
      drive(1, 1'b0, 12'h0, 1'b1, 1'b1, 1'b0);
      @(posedge Clk); #1;
      e = sb.pop_front(); g = obs(1); n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL count_up step %0d: got %h want %h", i, g, e);
      end
    end
  endtask

  task automatic test_count_down;
    exp_t e;
    exp_t g;
    drive(1, 1'b1, 12'h005, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk); #1;
      e = sb.pop_front(); g = obs(1); n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL count_down step %0d: got %h want %h", i, g, e);
      end
      drive(1, 1'b0, 12'h0, i < 7, 1'b0, 1'b0);
    end
    @(posedge Clk); #1;
    void'(sb.pop_front());
  endtask

  task automatic test_saturate;
    exp_t e;
    exp_t g;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0:       drive(1, 1'b1, 12'h058, 1'b0, 1'b1, 1'b1);
        4:       drive(1, 1'b1, 12'h001, 1'b0, 1'b0, 1'b1);
        default: drive(1, 1'b0, 12'h0, 1'b1, i < 4, 1'b1);
      endcase
      @(posedge Clk); #1;
      e = sb.pop_front(); g = obs(1); n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL saturate step %0d: got %h want %h", i, g, e);
      end
    end
  endtask

  task automatic test_load_err;
    exp_t e;
    exp_t g;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       drive(1, 1'b1, 12'h06A, 1'b0, 1'b1, 1'b0);
        1:       drive(1, 1'b0, 12'h0, 1'b0, 1'b1, 1'b0);
        2:       drive(1, 1'b1, 12'h047, 1'b1, 1'b1, 1'b0);
        default: drive(1, 1'b0, 12'h0, 1'b0, 1'b1, 1'b0);
      endcase
      @(posedge Clk); #1;
      e = sb.pop_front(); g = obs(1); n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL load_err step %0d: got %h want %h", i, g, e);
      end
    end
  endtask

  task automatic test_async_reset;
    exp_t e;
    exp_t g;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(1, 1'b1, 12'h031, 1'b0, 1'b1, 1'b0);
      else        drive(1, 1'b0, 12'h0, 1'b1, 1'b1, 1'b0);
      @(posedge Clk); #1;
      e = sb.pop_front(); g = obs(1); n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL async_pre step %0d: got %h want %h", i, g, e);
      end
    end
    #2;
    nReset = 1'b1;
    #1;
    m1 = 0; m2 = 0; m3 = 0;
    g = obs(1); n_cmp++;
    if (g !== exp_t'(0)) begin
      n_bad++;
      $display("FAIL async_reset: got %h want %h", g, exp_t'(0));
    end
    @(posedge Clk); #1;
    nReset = 1'b0;
    drive(1, 1'b0, 12'h0, 1'b1, 1'b1, 1'b0);
    @(posedge Clk); #1;
    e = sb.pop_front(); g = obs(1); n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL async_resume: got %h want %h", g, e);
    end
  endtask

  task automatic test_wide;
    exp_t e;
    exp_t g;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       drive(2, 1'b1, 12'h999, 1'b0, 1'b1, 1'b0);
        3:       drive(2, 1'b0, 12'h0, 1'b0, 1'b1, 1'b0);
        default: drive(2, 1'b0, 12'h0, 1'b1, 1'b1, 1'b0);
      endcase
      @(posedge Clk); #1;
      e = sb.pop_front(); g = obs(2); n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL wide step %0d: got %h want %h", i, g, e);
      end
    end
    drive(2, 1'b1, 12'h9A0, 1'b0, 1'b1, 1'b0);
    @(posedge Clk); #1;
    e = sb.pop_front(); g = obs(2); n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL wide_bad_load: got %h want %h", g, e);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    exp_t g;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       drive(3, 1'b1, 12'h001, 1'b0, 1'b1, 1'b0);
        4:       drive(3, 1'b0, 12'h0, 1'b0, 1'b1, 1'b0);
        default: drive(3, 1'b0, 12'h0, 1'b1, i != 2, 1'b0);
      endcase
      @(posedge Clk); #1;
      e = sb.pop_front(); g = obs(3); n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL back_to_back step %0d: got %h want %h", i, g, e);
      end
    end
  endtask

  initial begin
    nReset  = 1'b1;
    Enable  = 1'b0;
    Up      = 1'b0;
    Load    = 1'b0;
    SatMode = 1'b0;
    lv      = '0;
    test_reset();
    test_count_up();
    test_count_down();
    test_saturate();
    test_load_err();
    test_async_reset();
    test_wide();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bcd_time_counter.md
Name: bcd_time_counter

Overview:
Parametrised multi-digit BCD up/down counter for time-keeping displays. It generalises the single-digit mod-10 counter with:
- configurable digit count and top-digit modulus, e.g. 00–59 seconds;
- synchronous load with digit validation, up/down direction, and wrap or saturate mode;
- a registered carry/borrow pulse for cascading into the next stage (seconds to minutes).

It sits between the tick prescaler and the display/segment driver.

Parameters:
DIGITS, 2, number of BCD digits (1–8); digit 0 is least significant.
TOP_MOD, 6, modulus of the most significant digit (2–10); all lower digits are mod 10.
SAT_DEFAULT, 0, mode after reset: 0 = wrap, 1 = saturate.

Ports:
Clk  input  1  clock, all state updates on rising edge.
nReset  input  1  reset, asynchronous, active-high (1 = reset).
Enable  input  1  count strobe; one step per cycle while high.
Up  input  1  direction: 1 = increment, 0 = decrement.
Load  input  1  synchronous load request.
LoadValue  input  4*DIGITS  BCD value loaded when Load = 1.
SatMode  input  1  1 = saturate at limits, 0 = wrap; sampled every cycle.
PresentTime  output  4*DIGITS  current BCD count (registered).
Carry  output  1  one-cycle registered pulse on wrap (max to 0 when up, 0 to max when down).
AtLimit  output  1  registered; 1 while count = max (Up = 1) or count = 0 (Up = 0).
LoadErr  output  1  one-cycle registered pulse when a load is rejected.

Behaviour:
- Reset (nReset = 1, async):
  - PresentTime = 0, Carry = 0, LoadErr = 0.
  - AtLimit = 1 (count 0 with Up = 0) or 0 otherwise, evaluated after reset releases; registered value is 0 during reset.
  - Reset overrides everything, including mid-load and mid-count.
- MAX = top digit TOP_MOD-1, all other digits 9. MIN = all zeros.
- Priority per cycle: reset > Load > Enable > hold.
- Load:
  - Accepted if every lower digit ≤ 9 and the top digit ≤ TOP_MOD-1; PresentTime = LoadValue next cycle.
  - Otherwise PresentTime holds and LoadErr pulses for one cycle.
  - Load never asserts Carry. Load with Enable high ignores Enable that cycle.
- Increment (Enable = 1, Up = 1):
  - Digit 0 +1; a digit at 9 (top digit at TOP_MOD-1) rolls to 0 and ripples +1 into the next digit, all in the same cycle. Latency is 1 cycle.
  - At MAX, wrap mode: next = MIN and Carry = 1 for exactly one cycle.
  - At MAX, saturate mode: hold MAX, Carry = 0.
- Decrement (Enable = 1, Up = 0):
  - A digit at 0 rolls to 9 (top digit to TOP_MOD-1) and borrows from the next digit.
  - At MIN, wrap mode: next = MAX and Carry = 1.
  - At MIN, saturate mode: hold, Carry = 0.
- Carry and LoadErr deassert the cycle after assertion unless re-triggered. Back-to-back wraps with DIGITS = 1 and TOP_MOD = 2 give a Carry high on consecutive cycles.
- AtLimit: registered, computed from the next count and the current Up.
- Direction or SatMode changes take effect in the same cycle they are sampled; no pipeline state.
- Invalid internal codes are unreachable; nothing exceeds a digit's modulus.
- DIGITS = 1: the single digit uses TOP_MOD as its modulus.

Test Plan:
1. DIGITS = 2, TOP_MOD = 6: reset, Enable = 1, Up = 1 for 60 cycles -> PresentTime steps 0x00…0x09, 0x10…0x59, then 0x00. Carry is high only on the 0x59 -> 0x00 cycle, and AtLimit is high while the count is 0x59.
2. Load 0x05 then Up = 0, Enable for 7 cycles -> 0x04, 0x03, 0x02, 0x01, 0x00, 0x59 (Carry = 1), 0x58.
3. SatMode = 1, load 0x58, Up = 1, Enable for 3 cycles -> 0x59, 0x59, 0x59 with Carry never high. Same test with Up = 0 from 0x01 -> holds at 0x00.
4. Load 0x6A (top digit 6, lower digit A) -> PresentTime unchanged and LoadErr high for one cycle. Then load 0x47 with Enable = 1 -> 0x47 the next cycle (no increment) and no Carry.
5. Assert nReset asynchronously mid-cycle while counting at 0x33 -> PresentTime = 0x00 immediately and all pulses 0. After release, counting resumes from 0x00 on the next enabled edge.
6. DIGITS = 3, TOP_MOD = 10: load 0x999, Up = 1, Enable once -> 0x000 and Carry = 1. With Enable toggled 1/0/1 from 0x000 -> 0x001, 0x001, 0x002.
